// File: rtl/cancellable_delay_writer_pkg.sv
// Shared definitions for the cancellable delayed-write unit.
//   st_t        : per-channel FSM state (ST_IDLE, ST_WAIT)
//   DLY_ZERO_AS : cycle count loaded when a request asks for zero delay,
//                 so every accepted write commits at least one edge later.
package cancellable_delay_writer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } st_t;

  localparam int DLY_ZERO_AS = 1;

endpackage

// File: rtl/delay_writer_chan.sv
// One channel of the cancellable delayed-write unit: latches a word on
// start, counts down the requested delay, then commits the word to value.
// A cancel while pending drops the write and pulses cancelled.
// Optional feature (macro CANCELLABLE_DELAY_WRITER_RETRIGGER_EN): a start
// while pending restarts the delay with the new word and delay.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, start_data,
//   start_dly             : write request, word and delay in cycles
//   cancel                : abort the pending write
//   busy                  : a write is pending
//   value                 : last committed word
//   done, cancelled       : one-cycle pulses after commit / abort
module delay_writer_chan
  import cancellable_delay_writer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_data,
  input  logic [DLY_W-1:0] start_dly,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] value,
  output logic             done,
  output logic             cancelled
);

  st_t              state, state_n;
  logic [DLY_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [WIDTH-1:0] value_n;
  logic             done_n, cancelled_n;
  logic [DLY_W-1:0] load_cnt;

  // A zero delay still needs one edge to commit.
  assign load_cnt = (start_dly == '0) ? DLY_W'(DLY_ZERO_AS) : start_dly;
  assign busy     = (state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      value     <= '0;
      done      <= 1'b0;
      cancelled <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      value     <= value_n;
      done      <= done_n;
      cancelled <= cancelled_n;
    end
  end

  // The latched word needs no reset: it is only read after a start loads it.
  always_ff @(posedge clk) begin
    data_q <= data_n;
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    data_n      = data_q;
    value_n     = value;
    done_n      = 1'b0;
    cancelled_n = 1'b0;
    case (state)
      ST_IDLE: begin
        // Cancel in the same cycle suppresses the request silently.
        if (start && !cancel) begin
          data_n  = start_data;
          cnt_n   = load_cnt;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cancel) begin
          // Cancel beats expiry as well as any new start.
          state_n     = ST_IDLE;
          cancelled_n = 1'b1;
`ifdef CANCELLABLE_DELAY_WRITER_RETRIGGER_EN
        end else if (start) begin
          // Restart from this edge; the old write vanishes without a pulse.
          data_n = start_data;
          cnt_n  = load_cnt;
`endif
        end else if (cnt == DLY_W'(1)) begin
          value_n = data_q;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - DLY_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/cancellable_delay_writer.sv
// Multi-channel delayed-write unit with cancellation. Each channel is an
// independent delay_writer_chan; this level only slices the flat buses.
// Optional feature (macro CANCELLABLE_DELAY_WRITER_RETRIGGER_EN): a start
// on a pending channel restarts its delay with the new request.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : per-channel write request
//   start_data  : channel i word at [i*WIDTH +: WIDTH]
//   start_dly   : channel i delay at [i*DLY_W +: DLY_W]
//   cancel      : per-channel abort
//   busy        : per-channel pending flag
//   value       : channel i committed word at [i*WIDTH +: WIDTH]
//   done        : per-channel pulse in the cycle after a commit
//   cancelled   : per-channel pulse after an abort
module cancellable_delay_writer
  import cancellable_delay_writer_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DLY_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*WIDTH-1:0] start_data,
  input  logic [CHANNELS*DLY_W-1:0] start_dly,
  input  logic [CHANNELS-1:0]       cancel,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       cancelled
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    delay_writer_chan #(
      .WIDTH (WIDTH),
      .DLY_W (DLY_W)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .start      (start[i]),
      .start_data (start_data[i*WIDTH +: WIDTH]),
      .start_dly  (start_dly[i*DLY_W +: DLY_W]),
      .cancel     (cancel[i]),
      .busy       (busy[i]),
      .value      (value[i*WIDTH +: WIDTH]),
      .done       (done[i]),
      .cancelled  (cancelled[i])
    );
  end

endmodule

// File: tb/tb_cancellable_delay_writer.sv
module tb_cancellable_delay_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start;
  logic [7:0] start_data;
  logic [7:0] start_dly;
  logic [1:0] cancel;
  logic [1:0] busy;
  logic [7:0] value;
  logic [1:0] done;
  logic [1:0] cancelled;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         ch;
    logic [3:0] val;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  cancellable_delay_writer #(
    .WIDTH    (4),
    .CHANNELS (2),
    .DLY_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_data (start_data),
    .start_dly  (start_dly),
    .cancel     (cancel),
    .busy       (busy),
    .value      (value),
    .done       (done),
    .cancelled  (cancelled)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Commit monitor: each done pulse must match the oldest expectation of its channel.
  always @(negedge clk) begin : mon
    int idx;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ((done[c] & cancelled[c]) !== 1'b0) begin
        errors++;
        $display("FAIL both_pulses ch%0d cyc=%0d done=%b cancelled=%b required not both 1",
                 c, cyc, done[c], cancelled[c]);
      end
      if (done[c] === 1'b1) begin
        idx = -1;
        for (int k = 0; k < sb.size(); k++)
          if (idx < 0 && sb[k].ch == c) idx = k;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL unexpected_done ch%0d cyc=%0d value=%h required no commit",
                   c, cyc, value[c*4 +: 4]);
        end else begin
          if (value[c*4 +: 4] !== sb[idx].val || cyc != sb[idx].cyc) begin
            errors++;
            $display("FAIL commit ch%0d got value=%h at cyc %0d required value=%h at cyc %0d",
                     c, value[c*4 +: 4], cyc, sb[idx].val, sb[idx].cyc);
          end
          sb.delete(idx);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Present a one-cycle request; returns just after the accepting edge.
  task automatic issue(input int ch, input logic [3:0] d, input logic [3:0] dl);
    start_data[ch*4 +: 4] = d;
    start_dly[ch*4 +: 4]  = dl;
    start[ch]             = 1'b1;
    step();
    start[ch]             = 1'b0;
  endtask

  task automatic push(input int ch, input logic [3:0] v, input int at);
    exp_t e;
    e.ch = ch; e.val = v; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_commit pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b required 00", busy); end
    checks++;
    if (value !== 8'h00) begin errors++; $display("FAIL reset_value got %h required 00", value); end
    checks++;
    if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b required 00", done); end
    checks++;
    if (cancelled !== 2'b00) begin errors++; $display("FAIL reset_cancelled got %b required 00", cancelled); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    push(0, 4'h1, cyc + 2);
    issue(0, 4'h1, 4'd1);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL basic_busy got %b required 1", busy[0]); end
    step();
    checks++;
    if ({busy[0], value[3:0]} !== 5'b0_0001) begin
      errors++; $display("FAIL basic_after got busy=%b value=%h required busy=0 value=1", busy[0], value[3:0]);
    end
    step();
    drained("basic");
  endtask

  task automatic test_perm_cancel();
    do_reset();
    cancel[0]           = 1'b1;
    start_data[3:0]     = 4'h1;
    start_dly[3:0]      = 4'd1;
    start[0]            = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({busy[0], cancelled[0], value[3:0]} !== 6'b0) begin
        errors++;
        $display("FAIL perm_cancel cyc=%0d busy=%b cancelled=%b value=%h required 0 0 0",
                 cyc, busy[0], cancelled[0], value[3:0]);
      end
    end
    start[0]  = 1'b0;
    cancel[0] = 1'b0;
    step();
    drained("perm_cancel");
  endtask

  task automatic test_mid_cancel();
    issue(0, 4'h5, 4'd4);
    step();
    cancel[0] = 1'b1;
    step();
    cancel[0] = 1'b0;
    checks++;
    if ({cancelled[0], busy[0]} !== 2'b10) begin
      errors++; $display("FAIL mid_cancel_pulse got cancelled=%b busy=%b required 1 0", cancelled[0], busy[0]);
    end
    step();
    checks++;
    if ({cancelled[0], value[3:0]} !== 5'b0_0000) begin
      errors++; $display("FAIL mid_cancel_after got cancelled=%b value=%h required 0 0", cancelled[0], value[3:0]);
    end
    repeat (4) step();
    drained("mid_cancel");
  endtask

  task automatic test_cancel_expiry();
    issue(0, 4'hA, 4'd3);
    step();
    step();
    cancel[0] = 1'b1;
    step();
    cancel[0] = 1'b0;
    checks++;
    if ({cancelled[0], busy[0], value[3:0]} !== 6'b10_0000) begin
      errors++;
      $display("FAIL expiry_cancel got cancelled=%b busy=%b value=%h required 1 0 0",
               cancelled[0], busy[0], value[3:0]);
    end
    repeat (3) step();
    checks++;
    if (value[3:0] !== 4'h0) begin errors++; $display("FAIL expiry_value got %h required 0", value[3:0]); end
    drained("expiry");
  endtask

  task automatic test_zero_delay();
    push(0, 4'h9, cyc + 2);
    issue(0, 4'h9, 4'd0);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL zero_busy got %b required 1", busy[0]); end
    step();
    checks++;
    if ({busy[0], value[3:0]} !== 5'b0_1001) begin
      errors++; $display("FAIL zero_commit got busy=%b value=%h required busy=0 value=9", busy[0], value[3:0]);
    end
    step();
    drained("zero");
  endtask

  task automatic test_independent();
    do_reset();
    push(0, 4'h2, cyc + 3);
    start_data = 8'h62;
    start_dly  = 8'h22;
    start      = 2'b11;
    step();
    start      = 2'b00;
    checks++;
    if (busy !== 2'b11) begin errors++; $display("FAIL indep_busy got %b required 11", busy); end
    cancel[1] = 1'b1;
    step();
    cancel[1] = 1'b0;
    checks++;
    if ({cancelled, busy} !== 4'b10_01) begin
      errors++; $display("FAIL indep_cancel got cancelled=%b busy=%b required 10 01", cancelled, busy);
    end
    step();
    checks++;
    if ({busy, value} !== 10'b00_0000_0010) begin
      errors++; $display("FAIL indep_commit got busy=%b value=%h required 00 02", busy, value);
    end
    step();
    drained("indep");
  endtask

  task automatic test_busy_start();
`ifdef CANCELLABLE_DELAY_WRITER_RETRIGGER_EN
    push(0, 4'h7, cyc + 1 + 8);
`else
    push(0, 4'h3, cyc + 1 + 6);
`endif
    issue(0, 4'h3, 4'd6);
    step();
    issue(0, 4'h7, 4'd6);
    repeat (8) step();
    checks++;
`ifdef CANCELLABLE_DELAY_WRITER_RETRIGGER_EN
    if (value[3:0] !== 4'h7) begin errors++; $display("FAIL busy_start_value got %h required 7", value[3:0]); end
`else
    if (value[3:0] !== 4'h3) begin errors++; $display("FAIL busy_start_value got %h required 3", value[3:0]); end
`endif
    drained("busy_start");
  endtask

  task automatic test_reset_mid();
    issue(0, 4'hC, 4'd5);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, value, done, cancelled} !== 14'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b value=%h done=%b cancelled=%b required all 0",
               busy, value, done, cancelled);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({busy[0], cancelled[0], value[3:0]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_mid_after cyc=%0d busy=%b cancelled=%b value=%h required 0 0 0",
                 cyc, busy[0], cancelled[0], value[3:0]);
      end
    end
    drained("reset_mid");
  endtask

  initial begin
    reset      = 1'b1;
    start      = 2'b00;
    start_data = 8'h00;
    start_dly  = 8'h00;
    cancel     = 2'b00;
    test_reset();
    test_basic();
    test_perm_cancel();
    test_mid_cancel();
    test_cancel_expiry();
    test_zero_delay();
    test_independent();
    test_busy_start();
    test_reset_mid();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cancellable_delay_writer.md
Name: cancellable_delay_writer

Overview:
Multi-channel, parametrised delayed-write unit with cancellation. Each channel accepts a write of a data word with a programmed cycle delay. After that delay the word commits to the channel's output register. The write can be aborted at any point while it is pending. This is the clocked, synthesizable generalisation of "delayed assignment inside a task, killed by disable", used as a scheduling primitive in the test-infrastructure RTL.

Parameters:
- WIDTH, 4, bits per data word / output value
- CHANNELS, 2, number of independent channels
- DLY_W, 4, width of the per-request delay field (max delay 2**DLY_W-1 cycles)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  CHANNELS  per-channel write request, sampled at rising clk
- start_data  input  CHANNELS*WIDTH  word for channel i at [i*WIDTH +: WIDTH]
- start_dly  input  CHANNELS*DLY_W  delay for channel i at [i*DLY_W +: DLY_W]
- cancel  input  CHANNELS  per-channel abort of the pending write
- busy  output  CHANNELS  channel holds a pending write
- value  output  CHANNELS*WIDTH  committed word per channel
- done  output  CHANNELS  1-cycle pulse in the cycle after a commit edge
- cancelled  output  CHANNELS  1-cycle pulse when a pending write is aborted

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: busy=0, value=0, done=0, cancelled=0. Counters clear and all FSMs go to IDLE.
- Reset mid-operation drops the pending write with no commit and no cancelled pulse.
- Per-channel FSM has two states:
  - IDLE: on start=1 and cancel=0, latch data, load cnt=(dly==0 ? 1 : dly), go to WAIT, busy=1 from the next cycle.
  - WAIT: cnt decrements each edge.
    - At the edge where cnt==1 and cancel=0: value<=latched data, done=1 for one cycle, go to IDLE, busy=0.
    - cancel=1 in WAIT: go to IDLE, value unchanged, cancelled=1 for one cycle, no done.
- Latency: a start accepted at edge t0 with delay d commits at edge t0+max(d,1).
- Simultaneous events:
  - start and cancel in the same IDLE cycle: cancel wins. The request is dropped, with no cancelled pulse.
  - cancel on the expiry edge: cancel wins, no commit.
  - start while in WAIT: ignored (unless the optional feature is enabled).
  - cancel in IDLE: no effect.
- Channels are fully independent. There is no shared arbitration.
- done and cancelled are never high together on the same channel.

Optional Feature:
- Macro: CANCELLABLE_DELAY_WRITER_RETRIGGER_EN
- Defined: start=1 (with cancel=0) in WAIT reloads data and counter from the new request, and restarts the delay from that edge. The old write is discarded without a cancelled pulse.
- Undefined: start in WAIT is ignored as specified above.

Decomposition:
- Package cancellable_delay_writer_pkg holds:
  - the state enum {ST_IDLE, ST_WAIT};
  - the constant DLY_ZERO_AS = 1.
- One sub-module, delay_writer_chan, holds one channel's FSM, counter, data latch and pulses. The top generates CHANNELS instances and does the bus slicing.

Test Plan:
- Basic commit: ch0, start data=1, dly=1 -> value[3:0]=1 one edge later, done pulse, busy back to 0.
- Permanent cancel: value=0, start data=1, dly=1, cancel held high every cycle -> value stays 0 through 10 cycles, no done, busy never 1.
- Mid-wait cancel: start data=5, dly=4, cancel at t0+2 -> cancelled pulse at t0+3, value unchanged, no done at t0+4.
- Cancel on expiry edge: start dly=3, cancel at the third edge -> no commit.
- Zero delay: start data=9, dly=0 -> commits after 1 cycle.
- Independent channels: ch0 dly=2, ch1 dly=2 cancelled -> only ch0 commits.
- Busy start: start dly=6 data=3, then start data=7 at t0+2 -> without the macro, commit 3 at t0+6; with the macro, commit 7 at t0+8.
- Reset at t0+2 of a dly=5 request -> all outputs 0, no later commit.
